// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl: set-associative write-through, read-allocate data cache
// for the MEM stage. Ports: clk, rst (async, high), MEM_R_EN/MEM_W_EN,
// ALU_res, ST_Value, read_data, Ready, sram_r_en/w_en/addr/wdata/rdata,
// sram_ready. Optional macro CACHE_STATS_EN adds hit_count/miss_count.
module mem_cache_ctrl #(
  parameter int          SETS        = 64,
  parameter int          WAYS        = 2,
  parameter int          BLOCK_WORDS = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MEM_R_EN,
  input  logic                      MEM_W_EN,
  input  logic [31:0]               ALU_res,
  input  logic [31:0]               ST_Value,
  output logic [31:0]               read_data,
  output logic                      Ready,
  output logic                      sram_r_en,
  output logic                      sram_w_en,
  output logic [31:0]               sram_addr,
  output logic [31:0]               sram_wdata,
  input  logic [32*BLOCK_WORDS-1:0] sram_rdata,
  input  logic                      sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF  = $clog2(BLOCK_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - OFF - IDX;
  localparam int OFFW = (OFF > 0) ? OFF : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_t;

  state_t state;

  logic [29:0]      waddr;
  logic [29:0]      blk_waddr;
  logic [OFFW-1:0]  offset;
  logic [IDX-1:0]   index;
  logic [TAGW-1:0]  tag;

  assign waddr     = 30'((ALU_res - BASE_ADDR) >> 2);
  assign blk_waddr = waddr & ~30'(BLOCK_WORDS - 1);
  assign offset    = (OFF > 0) ? waddr[OFFW-1:0] : '0;
  assign index     = waddr[OFF +: IDX];
  assign tag       = waddr[29 -: TAGW];

  logic [WAYS-1:0] valid [SETS];
  logic [SETS-1:0] lru;
  logic [TAGW-1:0] tags  [WAYS][SETS];
  logic [31:0]     data  [WAYS][SETS][BLOCK_WORDS];

  logic        hit;
  logic        hit_way;
  logic        victim;
  logic [31:0] hit_word;
  logic        fill;
  logic        wr_hit;
  logic        ld_hit;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[index][w] && tags[w][index] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Empty ways fill first (way 0 before way 1); LRU only when both full.
  always_comb begin
    victim = 1'b0;
    if (!valid[index][0])
      victim = 1'b0;
    else if (WAYS == 2 && !valid[index][WAYS-1])
      victim = 1'b1;
    else if (WAYS == 2)
      victim = lru[index];
  end

  assign hit_word = data[hit_way][index][offset];
  assign ld_hit   = (state == IDLE) && MEM_R_EN && !MEM_W_EN && hit;
  assign fill     = (state == RD_MISS) && sram_ready;
  assign wr_hit   = (state == WR) && sram_ready && hit;

  always_comb begin
    Ready = 1'b1;
    unique case (state)
      IDLE:    Ready = !(MEM_W_EN || (MEM_R_EN && !hit));
      default: Ready = sram_ready;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (ld_hit)
      read_data = hit_word;
    else if (fill)
      read_data = sram_rdata[32*offset +: 32];
  end

  assign sram_addr  = {2'b00, (state == RD_MISS) ? blk_waddr : waddr};
  assign sram_wdata = ST_Value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sram_r_en <= 1'b0;
      sram_w_en <= 1'b0;
      lru       <= '0;
      for (int s = 0; s < SETS; s++)
        valid[s] <= '0;
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state     <= WR;
            sram_w_en <= 1'b1;
          end else if (MEM_R_EN) begin
            if (hit) begin
              lru[index] <= ~hit_way;
`ifdef CACHE_STATS_EN
              hit_count <= hit_count + 32'd1;
`endif
            end else begin
              state     <= RD_MISS;
              sram_r_en <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            valid[index][victim] <= 1'b1;
            lru[index]           <= ~victim;
            sram_r_en            <= 1'b0;
            state                <= IDLE;
`ifdef CACHE_STATS_EN
            miss_count <= miss_count + 32'd1;
`endif
          end
        end
        WR: begin
          if (sram_ready) begin
            if (hit)
              lru[index] <= ~hit_way;
            sram_w_en <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; writes only happen in RD_MISS/WR,
  // which reset leaves immediately, so abandoned transactions write nothing.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[victim][index] <= tag;
      for (int k = 0; k < BLOCK_WORDS; k++)
        data[victim][index][k] <= sram_rdata[32*k +: 32];
    end
    if (wr_hit)
      data[hit_way][index][offset] <= ST_Value;
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl: directed + random self-checking bench for
// mem_cache_ctrl against a recency-list cache and word-memory model.
module tb_mem_cache_ctrl;

  localparam int NSETS = 64;
  localparam int NWAYS = 2;
  localparam int BW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN;
  logic          MEM_W_EN;
  logic [31:0]   ALU_res;
  logic [31:0]   ST_Value;
  logic [31:0]   read_data;
  logic          Ready;
  logic          sram_r_en;
  logic          sram_w_en;
  logic [31:0]   sram_addr;
  logic [31:0]   sram_wdata;
  logic [63:0]   sram_rdata;
  logic          sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  mem_cache_ctrl #(
    .SETS(NSETS), .WAYS(NWAYS), .BLOCK_WORDS(BW), .BASE_ADDR(32'd1024)
  ) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_res(ALU_res), .ST_Value(ST_Value),
    .read_data(read_data), .Ready(Ready),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned mem [int unsigned];
  int unsigned cq [NSETS][$];
  int          n_hit = 0;
  int          n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned memrd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic int find(input int s, input int unsigned b);
    foreach (cq[s][i])
      if (cq[s][i] == b) return i;
    return -1;
  endfunction

  task automatic touch(input int s, input int unsigned b);
    int p;
    p = find(s, b);
    if (p >= 0) cq[s].delete(p);
    cq[s].push_front(b);
    if (cq[s].size() > NWAYS) void'(cq[s].pop_back());
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) cq[s].delete();
    n_hit  = 0;
    n_miss = 0;
  endtask

  task automatic do_load(input logic [31:0] addr, input int lat,
                         output bit was_hit);
    int unsigned w, b, bw0;
    int s;
    bit mh;
    w   = (addr - 32'd1024) >> 2;
    b   = w / BW;
    bw0 = b * BW;
    s   = b % NSETS;
    mh  = find(s, b) >= 0;
    @(negedge clk);
    sram_ready = 1'b0;
    MEM_W_EN   = 1'b0;
    MEM_R_EN   = 1'b1;
    ALU_res    = addr;
    #1;
    was_hit = Ready;
    chk("ld_ready0", Ready, mh);
    chk("ld_ren0", sram_r_en, 0);
    if (mh) begin
      chk("hit_data", read_data, memrd(w));
      n_hit++;
    end else begin
      chk("miss_data0", read_data, 0);
      for (int n = 1; n <= lat; n++) begin
        @(negedge clk);
        if (n == lat) begin
          sram_ready = 1'b1;
          sram_rdata = {memrd(bw0 + 1), memrd(bw0)};
        end else begin
          sram_rdata = {$urandom, $urandom};
        end
        #1;
        chk("miss_ren", sram_r_en, 1);
        chk("miss_addr", sram_addr, bw0);
        chk("miss_ready", Ready, n == lat);
        if (n == lat) chk("miss_data", read_data, memrd(w));
      end
      n_miss++;
    end
    touch(s, b);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] d,
                          input int lat, input bit rd);
    int unsigned w, b;
    int s;
    w = (addr - 32'd1024) >> 2;
    b = w / BW;
    s = b % NSETS;
    @(negedge clk);
    sram_ready = 1'b0;
    MEM_W_EN   = 1'b1;
    MEM_R_EN   = rd;
    ALU_res    = addr;
    ST_Value   = d;
    #1;
    chk("st_ready0", Ready, 0);
    chk("st_wen0", sram_w_en, 0);
    chk("st_rdata0", read_data, 0);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == lat) sram_ready = 1'b1;
      #1;
      chk("st_wen", sram_w_en, 1);
      chk("st_ren", sram_r_en, 0);
      chk("st_addr", sram_addr, w);
      chk("st_wdata", sram_wdata, d);
      chk("st_ready", Ready, n == lat);
      chk("st_rdata", read_data, 0);
    end
    mem[w] = d;
    if (find(s, b) >= 0) touch(s, b);
  endtask

  task automatic do_idle();
    @(negedge clk);
    sram_ready = 1'b0;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    #1;
    chk("idle_ready", Ready, 1);
    chk("idle_rdata", read_data, 0);
    chk("idle_ren", sram_r_en, 0);
    chk("idle_wen", sram_w_en, 0);
  endtask

  function automatic logic [31:0] mk(input int t, input int s,
                                     input int o);
    return 32'd1024 + 32'((((t * NSETS) + s) * BW + o) * 4);
  endfunction

  bit h;

  initial begin
    rst        = 1'b1;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    ALU_res    = 32'd1024;
    ST_Value   = '0;
    sram_rdata = '0;
    sram_ready = 1'b0;
    model_reset();
    mem[0] = 32'hAAAA0001;
    mem[1] = 32'hBBBB0002;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", Ready, 1);
    chk("rst_ren", sram_r_en, 0);
    chk("rst_wen", sram_w_en, 0);
    chk("rst_rdata", read_data, 0);
    rst = 1'b0;

    // reset in the middle of a miss
    @(negedge clk);
    MEM_R_EN = 1'b1;
    ALU_res  = 32'd1024;
    #1;
    chk("rm_ready0", Ready, 0);
    @(negedge clk);
    #1;
    chk("rm_ren", sram_r_en, 1);
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    #1;
    chk("rm_ren_drop", sram_r_en, 0);
    chk("rm_ready", Ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // cold read, then neighbour hit
    do_load(32'd1024, 4, h);
    chk("cold_miss", h, 0);
    do_load(32'd1028, 1, h);
    chk("nbr_hit", h, 1);
`ifdef CACHE_STATS_EN
    #1;
    chk("stat_hit", hit_count, 1);
    chk("stat_miss", miss_count, 1);
`endif

    // write-through with update, then no-allocate store
    do_store(32'd1024, 32'h12345678, 3, 1'b0);
    do_load(32'd1024, 2, h);
    chk("wt_hit", h, 1);
    do_store(mk(7, 5, 1), 32'hCAFEF00D, 2, 1'b0);
    do_load(mk(7, 5, 1), 2, h);
    chk("noalloc_miss", h, 0);

    // LRU in set 0
    do_load(mk(1, 0, 0), 2, h);
    do_load(mk(2, 0, 1), 2, h);
    do_load(mk(1, 0, 1), 1, h);
    chk("lru_a_rehit", h, 1);
    do_load(mk(3, 0, 0), 2, h);
    chk("lru_c_miss", h, 0);
    do_load(mk(1, 0, 0), 1, h);
    chk("lru_a_hit", h, 1);
    do_load(mk(2, 0, 0), 2, h);
    chk("lru_b_miss", h, 0);

    // read+write together performs only the write
    do_store(mk(9, 3, 0), 32'h0BADBEEF, 2, 1'b1);
    do_load(mk(9, 3, 0), 2, h);
    chk("prio_noalloc", h, 0);
    do_idle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = mk($urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 1));
      if (r < 6)
        do_load(a, $urandom_range(1, 4), h);
      else if (r < 9)
        do_store(a, $urandom, $urandom_range(1, 4), 1'($urandom));
      else
        do_idle();
    end
    do_idle();
`ifdef CACHE_STATS_EN
    chk("stat_hit_end", hit_count, n_hit);
    chk("stat_miss_end", miss_count, n_miss);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_cache_ctrl.md
# mem_cache_ctrl

Parametrised set-associative, write-through, read-allocate data cache controller for the MEM stage of the ARM pipeline. Sits between the pipeline's memory request (ALU result, store value, read/write enables) and the SRAM controller. Serves read hits in zero stall cycles and fetches whole blocks from SRAM on a read miss. Forwards every store to SRAM and updates the cached copy on a write hit. Drives the stage `Ready` signal that freezes the pipeline while SRAM traffic is outstanding.

## Interface

- `SETS`, 64: number of sets; a power of two, 4 or more.
- `WAYS`, 2: associativity; 1 (direct-mapped) or 2 (LRU).
- `BLOCK_WORDS`, 2: 32-bit words per block; a power of two, 1–4.
- `BASE_ADDR`, 1024: data memory base, subtracted from `ALU_res`.

Ports:

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `MEM_R_EN` in 1: load request.
- `MEM_W_EN` in 1: store request.
- `ALU_res` in 32: byte address.
- `ST_Value` in 32: store data.
- `read_data` out 32: load data.
- `Ready` out 1: stage may advance.
- `sram_r_en` out 1: block read request to the SRAM controller.
- `sram_w_en` out 1: word write request.
- `sram_addr` out 32: word address, offset from `BASE_ADDR`. Block-aligned for reads.
- `sram_wdata` out 32: equals `ST_Value`.
- `sram_rdata` in 32*`BLOCK_WORDS`: fetched block; word 0 is in the LSBs.
- `sram_ready` in 1: one-cycle completion pulse from the SRAM controller.

## Operation

**Address decode**
- `waddr = (ALU_res - BASE_ADDR) >> 2`.
- `offset = waddr[OFF-1:0]` with `OFF = log2(BLOCK_WORDS)`.
- `index` is the next `log2(SETS)` bits.
- `tag` is the remaining bits of the 30-bit `waddr`.

**Storage and replacement**
- Per way: valid bit, tag array and data array.
- Per set, only when `WAYS=2`: one LRU bit naming the victim.
- Hit means some way has its valid bit set and a matching tag.

**State machine:** `IDLE`, `RD_MISS`, `WR`.
- `IDLE`, `MEM_W_EN=1`: go to `WR`. If `MEM_R_EN` is also 1, the write has priority and the read is ignored.
- `IDLE`, `MEM_R_EN=1`, hit: stay in `IDLE`. `read_data` = the hit word; LRU points to the other way.
- `IDLE`, `MEM_R_EN=1`, miss: go to `RD_MISS`.
- `RD_MISS`: `sram_r_en=1`, `sram_addr` = `waddr` with the offset bits cleared.
  - On `sram_ready=1`: write the block into the victim way, set its valid bit and tag, and update LRU.
  - In the same cycle, `read_data` bypasses the selected word from `sram_rdata`. Return to `IDLE`.
- Victim selection: an invalid way is preferred, with way 0 first. Otherwise the LRU way is evicted.
- `WR`: `sram_w_en=1`, `sram_addr=waddr`.
  - On `sram_ready=1`: if the address hits, overwrite that word and update LRU. On a miss, no allocation. Return to `IDLE`.
- `sram_ready` is ignored in `IDLE`.
- The pipeline holds all request inputs stable while `Ready=0`.

**Outputs**
- `Ready` is combinational.
  - 1 in `IDLE` unless a miss or a write is being detected that cycle.
  - 1 in `RD_MISS` and `WR` only in the `sram_ready` cycle.
- `read_data` is 0 when no load is being answered.

## Timing

- **Reset values:** state `IDLE`, all valid and LRU bits 0, `Ready=1`, `sram_r_en=0`, `sram_w_en=0`, `read_data=0`. Data and tag arrays are not reset.
- **Reset mid-operation:** reset asserted in `RD_MISS` or `WR` drops the SRAM enables immediately. The transaction is abandoned with no array update.
- **Read hit:** 0 stall cycles; data is valid in the request cycle.
- **Read miss:**
  - Cycle 0: `Ready=0`.
  - From cycle 1: `sram_r_en` held.
  - Cycle N, with `sram_ready`: `Ready=1` and data valid.
  - Total stall is N cycles.
- **Write:** same shape as a read miss, using `sram_w_en`.
- **Back-to-back:** a new request may be accepted in the cycle after `Ready=1`. A read immediately after a write to the same address returns the new value.

## Configuration

- Macro `CACHE_STATS_EN`. When defined, the block adds:
  - Outputs `hit_count` and `miss_count`, 32 bits each.
  - Each increments once per completed load (hit in `IDLE`, miss at `sram_ready`), wrapping modulo 2^32.
  - Both are cleared by `rst`.
- When undefined, neither port nor counter exists.

## Test plan

- **Reset:** assert `rst` mid-miss. Expect `sram_r_en` 0 immediately, `Ready=1`. A reload of the same address then misses again.
- **Cold read:** load 1024 with the SRAM returning block `{0xBBBB0002, 0xAAAA0001}` after 4 cycles.
  - Expect `Ready=0` for 4 cycles and `read_data=0xAAAA0001`.
  - A load of 1028 then hits with 0 stalls and returns `0xBBBB0002`.
- **Write-through:** store `0x12345678` to 1024 after it is cached.
  - Expect `sram_w_en` with `sram_addr=0` and `sram_wdata=0x12345678`.
  - A following load of 1024 hits and returns `0x12345678`.
  - A store to an uncached address does not allocate.
- **LRU (`WAYS=2`, `SETS=64`, `BLOCK_WORDS=2`):** load addresses A, B, C mapping to set 0 with distinct tags, with a re-read of A before C.
  - C evicts B.
  - A hits and B misses afterwards.
- **Priority:** `MEM_R_EN=MEM_W_EN=1` performs only the write.
- **Stats (`CACHE_STATS_EN`):** the cold-read scenario gives `hit_count=1`, `miss_count=1`.
